// File: rtl/data_unpacker_pkg.sv
// Shared trace packing definitions: mode encodings, default geometry and
// the unpacker state type. The packer and the unpacker both import this
// package, so their mode encodings cannot drift apart.
package data_unpacker_pkg;

  typedef enum logic [1:0] {
    PACK_N = 2'd0,
    PACK_M = 2'd1,
    PACK_1 = 2'd2
  } pack_mode_t;

  // Mode value 3 is reserved and is treated as an error.
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;

  localparam int DEF_N          = 8;
  localparam int DEF_M          = 2;
  localparam int DEF_DATA_WIDTH = 32;

  // Width needed to hold a fill count in the range 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_t;

endpackage

// File: rtl/data_unpacker_unpack_shifter.sv
// Combinational block extractor. It takes the held packed vector, selects
// `length` elements starting at rd_ptr, left-aligns them at lane 0 and
// zeroes every lane at or above `length`.
module unpack_shifter #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 4
) (
  input  logic [N-1:0][DATA_WIDTH-1:0] held,
  input  logic [CW-1:0]                rd_ptr,
  input  logic [CW-1:0]                length,
  output logic [N-1:0][DATA_WIDTH-1:0] vector_out
);

  logic [N*DATA_WIDTH-1:0] flat;
  logic [N*DATA_WIDTH-1:0] shifted;

  // Shift the held vector down by rd_ptr lanes, then zero the unused lanes.
  always_comb begin
    flat       = held;
    shifted    = flat >> (int'(rd_ptr) * DATA_WIDTH);
    vector_out = '0;
    for (int i = 0; i < N; i++) begin
      if (i < int'(length)) begin
        vector_out[i] = shifted[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/data_unpacker.sv
// Trace readback unpacker. Takes one packed N-wide vector with its packing
// mode and fill count, and re-emits the original blocks of N, M or 1
// elements, oldest first, one block per output handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid_out never retracts: once raised, vector_out,
// length_out and last_out hold until ready_out takes the block. ready_in is
// a combinational function of state and ready_out only, never of valid_in.
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int M          = DEF_M,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [1:0]                    mode_in,
  input  logic [$clog2(N+1)-1:0]        count_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]  vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
  output logic [$clog2(N+1)-1:0]        length_out,
  output logic                          last_out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic                          err_out,
  output logic                          state_dbg
);

  localparam int CW = count_width(N);

  unpack_state_t                state;
  pack_mode_t                   mode_q;
  logic [N-1:0][DATA_WIDTH-1:0] held;
  logic [CW-1:0]                rd_ptr;
  logic                         err_q;

  logic [CW-1:0] blk_size;
  logic [CW-1:0] remain;
  logic [CW-1:0] blk_len;
  logic [CW-1:0] eff_count;
  logic          count_over;
  logic          mode_bad;
  logic          take;
  logic          accept;

  // Current block geometry, handshake terms and input qualification.
  always_comb begin
    case (mode_q)
      PACK_N:  blk_size = CW'(N);
      PACK_M:  blk_size = CW'(M);
      default: blk_size = CW'(1);
    endcase
    remain     = CW'(N) - rd_ptr;
    blk_len    = '0;
    if (state == ST_DRAIN) begin
      blk_len = (blk_size < remain) ? blk_size : remain;
    end
    valid_out  = (state == ST_DRAIN);
    last_out   = valid_out && (blk_len == remain);
    take       = valid_out && ready_out;
    // A new vector may arrive in the same cycle the final block leaves.
    ready_in   = !reset && ((state == ST_IDLE) || (take && last_out));
    accept     = valid_in && ready_in;
    count_over = (count_in > CW'(N));
    eff_count  = count_over ? CW'(N) : count_in;
    mode_bad   = (mode_in == MODE_ILLEGAL);
  end

  // Load on accept, advance the read pointer on each taken block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= PACK_N;
      held   <= '0;
      rd_ptr <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept && (mode_bad || count_over)) begin
        err_q <= 1'b1;
      end
      if (accept) begin
        if (!mode_bad && (eff_count != '0)) begin
          held   <= vector_in;
          mode_q <= pack_mode_t'(mode_in);
          rd_ptr <= CW'(N) - eff_count;
          state  <= ST_DRAIN;
        end else begin
          // Empty or illegal vectors are swallowed without output.
          state <= ST_IDLE;
        end
      end else if (take) begin
        rd_ptr <= rd_ptr + blk_len;
        if (last_out) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign length_out = blk_len;
  assign err_out    = err_q;
  assign state_dbg  = (state == ST_DRAIN);

  unpack_shifter #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH),
    .CW         (CW)
  ) u_shifter (
    .held       (held),
    .rd_ptr     (rd_ptr),
    .length     (blk_len),
    .vector_out (vector_out)
  );

endmodule

// File: tb/tb_data_unpacker.sv
// Bench for data_unpacker with N=8, M=2, DATA_WIDTH=32. A queue-based model
// turns every accepted vector into its list of expected blocks; a negedge
// compare process checks the DUT against the head of that list every cycle.
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;

  typedef logic [N-1:0][DW-1:0] vec_t;

  typedef struct {
    vec_t data;
    int   len;
    bit   last;
  } blk_t;

  logic       clk;
  logic       reset;
  logic       valid_in;
  logic       ready_in;
  logic [1:0] mode_in;
  logic [3:0] count_in;
  vec_t       vector_in;
  vec_t       vector_out;
  logic [3:0] length_out;
  logic       last_out;
  logic       valid_out;
  logic       ready_out;
  logic       err_out;
  logic       state_dbg;

  int   err_cnt = 0;
  int   chk_cnt = 0;
  bit   chk_en  = 0;
  blk_t exp_q[$];
  bit   m_err   = 0;

  data_unpacker #(.N(N), .M(M), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .mode_in    (mode_in),
    .count_in   (count_in),
    .vector_in  (vector_in),
    .vector_out (vector_out),
    .length_out (length_out),
    .last_out   (last_out),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .err_out    (err_out),
    .state_dbg  (state_dbg)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand one accepted vector into its expected output blocks.
  function automatic void model_accept(input logic [1:0] md, input logic [3:0] cnt, input vec_t v);
    int   eff;
    int   blk;
    int   p;
    blk_t b;
    eff = (cnt > 4'd8) ? 8 : int'(cnt);
    if (cnt > 4'd8 || md == 2'd3) m_err = 1;
    if (md != 2'd3 && eff > 0) begin
      blk = (md == 2'd0) ? N : (md == 2'd1) ? M : 1;
      p = N - eff;
      while (p < N) begin
        b.data = '0;
        b.len  = (blk < N - p) ? blk : N - p;
        for (int i = 0; i < b.len; i++) b.data[i] = v[p+i];
        p += b.len;
        b.last = (p == N);
        exp_q.push_back(b);
      end
    end
  endfunction

  // Model update on each rising edge: retire the taken block, then load.
  always @(posedge clk) begin
    bit mr;
    mr = (exp_q.size() == 0) || (exp_q.size() == 1 && ready_out);
    if (reset) begin
      exp_q.delete();
      m_err = 0;
    end else begin
      if (exp_q.size() > 0 && ready_out) void'(exp_q.pop_front());
      if (valid_in && mr) model_accept(mode_in, count_in, vector_in);
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    bit exp_ready;
    if (chk_en) begin
      exp_ready = !reset && ((exp_q.size() == 0) || (exp_q.size() == 1 && ready_out));
      check("ready_in", ready_in, exp_ready);
      check("valid_out", valid_out, exp_q.size() > 0);
      check("state_dbg", state_dbg, exp_q.size() > 0);
      check("err_out", err_out, m_err);
      if (exp_q.size() > 0) begin
        check("length_out", length_out, exp_q[0].len);
        check("last_out", last_out, exp_q[0].last);
        check("vector_out", vector_out, exp_q[0].data);
      end else begin
        check("vector_out_idle", vector_out, 0);
        check("length_out_idle", length_out, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a vector on the input until it is accepted (bounded wait).
  task automatic present(input logic [1:0] md, input logic [3:0] cnt, input vec_t v);
    bit acc;
    valid_in  = 1'b1;
    mode_in   = md;
    count_in  = cnt;
    vector_in = v;
    acc = 0;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
    end
    check("accept_wait", acc, 1);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    vec_t v;
    vec_t v2;
    reset     = 1'b1;
    valid_in  = 1'b0;
    mode_in   = 2'd0;
    count_in  = 4'd0;
    vector_in = '0;
    ready_out = 1'b1;
    repeat (3) step();
    chk_en = 1;
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_len", length_out, 0);
    check("rst_err", err_out, 0);
    check("rst_ready", ready_in, 0);
    step();
    reset = 1'b0;

    // Mode 0, full vector.
    for (int i = 0; i < N; i++) v[i] = DW'(i + 1);
    present(2'd0, 4'd8, v);
    valid_in = 1'b0;
    @(negedge clk);
    check("t1_valid", valid_out, 1);
    check("t1_len", length_out, 8);
    check("t1_last", last_out, 1);
    check("t1_lane0", vector_out[0], 1);
    check("t1_lane7", vector_out[7], 8);
    @(negedge clk);
    check("t1_idle", valid_out, 0);
    step();

    // Mode 2, count 3.
    v = '0;
    v[5] = 32'hA; v[6] = 32'hB; v[7] = 32'hC;
    present(2'd2, 4'd3, v);
    valid_in = 1'b0;
    @(negedge clk);
    check("t2_a", vector_out[0], 32'hA);
    check("t2_a_last", last_out, 0);
    check("t2_a_rdy", ready_in, 0);
    @(negedge clk);
    check("t2_b", vector_out[0], 32'hB);
    check("t2_b_rdy", ready_in, 0);
    @(negedge clk);
    check("t2_c", vector_out[0], 32'hC);
    check("t2_c_last", last_out, 1);
    step();

    // Mode 1, count 5.
    v = '0;
    for (int i = 3; i < N; i++) v[i] = DW'(i + 7);
    present(2'd1, 4'd5, v);
    valid_in = 1'b0;
    @(negedge clk);
    check("t3_b0", {vector_out[1], vector_out[0]}, {32'd11, 32'd10});
    check("t3_len0", length_out, 2);
    @(negedge clk);
    check("t3_b1", {vector_out[1], vector_out[0]}, {32'd13, 32'd12});
    @(negedge clk);
    check("t3_b2", vector_out[0], 14);
    check("t3_len2", length_out, 1);
    check("t3_zero", vector_out >> DW, 0);
    step();

    // Backpressure with ready_out toggling every cycle.
    for (int i = 0; i < N; i++) v[i] = $urandom;
    present(2'd1, 4'd8, v);
    valid_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      ready_out = ~ready_out;
      step();
    end
    ready_out = 1'b1;
    repeat (3) step();

    // Back-to-back mode-2 count-2 vectors.
    for (int i = 0; i < N; i++) begin
      v[i]  = $urandom;
      v2[i] = $urandom;
    end
    present(2'd2, 4'd2, v);
    present(2'd2, 4'd2, v2);
    valid_in = 1'b0;
    @(negedge clk);
    check("b2b_nobubble", vector_out[0], v2[6]);
    repeat (3) step();

    // Illegal mode sets the sticky error.
    present(2'd3, 4'd4, v);
    valid_in = 1'b0;
    @(negedge clk);
    check("e_mode_err", err_out, 1);
    check("e_mode_valid", valid_out, 0);
    repeat (2) @(negedge clk);
    check("e_mode_sticky", err_out, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Count 0 is swallowed without an error.
    present(2'd1, 4'd0, v);
    valid_in = 1'b0;
    @(negedge clk);
    check("e_cnt0_valid", valid_out, 0);
    check("e_cnt0_err", err_out, 0);
    step();

    // Over-range count clamps to N and flags an error.
    present(2'd1, 4'd12, v);
    valid_in = 1'b0;
    @(negedge clk);
    check("e_over_err", err_out, 1);
    check("e_over_len", length_out, 2);
    check("e_over_lane0", vector_out[0], v[0]);
    repeat (4) step();

    // Reset in the middle of a drain.
    present(2'd1, 4'd8, v);
    valid_in = 1'b0;
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check("rd_valid", valid_out, 0);
    check("rd_err", err_out, 0);
    step();
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rd_quiet", valid_out, 0);
    end
    step();

    // Randomized traffic.
    for (int it = 0; it < 600; it++) begin
      int r;
      valid_in = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      mode_in = (r == 9) ? 2'd3 : 2'(r % 3);
      r = $urandom_range(0, 10);
      count_in = (r > 8) ? 4'($urandom_range(9, 15)) : 4'(r);
      for (int i = 0; i < N; i++) vector_in[i] = $urandom;
      ready_out = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end

    // Drain and finish.
    valid_in  = 1'b0;
    ready_out = 1'b1;
    reset     = 1'b0;
    repeat (20) step();
    @(negedge clk);
    check("final_idle", valid_out, 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
